// File: rtl/uart_serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Each bit is held for CLKS_PER_BIT clocks; serial_o is driven straight from a flop.
module uart_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              serial_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic [2:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bitIdx;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic              r_serial;
  logic              r_done;

  logic              w_tick;
  logic              w_accept;
  logic [DATA_W-1:0] w_shiftNext;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_accept    = valid_i && (r_state == S_IDLE);
  assign w_shiftNext = r_shift >> 1;

  // Divider restarts in IDLE so every bit, including the start bit, gets a full period.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_div <= '0;
    end else if (r_state == S_IDLE || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_serial <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_serial <= 1'b1;
          if (w_accept) begin
            r_state  <= S_START;
            r_serial <= 1'b0;
            r_shift  <= data_i;
            r_parity <= ^data_i;
            r_bitIdx <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state  <= S_DATA;
            r_serial <= r_shift[0];
          end
        end
        // Next line value is loaded one cycle early so serial_o stays a pure register.
        S_DATA: begin
          if (w_tick) begin
            r_shift <= w_shiftNext;
            if (r_bitIdx == BIT_LAST) begin
              r_state  <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              r_serial <= (PARITY_EN != 0) ? r_parity : 1'b1;
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
              r_serial <= w_shiftNext[0];
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_state  <= S_STOP;
            r_serial <= 1'b1;
          end
        end
        S_STOP: begin
          r_serial <= 1'b1;
          if (w_tick) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign serial_o = r_serial;
  assign done_o   = r_done;

endmodule

// File: tb/tb_uart_serial_tx.sv
// Bench for uart_serial_tx: three instances (8/4/no parity, 8/4/parity, 4/1/no parity)
// compared cycle by cycle against a bit-list model of the frame.
module tb_uart_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid  [3];
  logic [7:0] data   [3];
  logic       ready  [3];
  logic       serial [3];
  logic       busy   [3];
  logic       done   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .serial_o(serial[0]), .busy_o(busy[0]), .done_o(done[0]));

  uart_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .serial_o(serial[1]), .busy_o(busy[1]), .done_o(done[1]));

  uart_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data[2][3:0]), .valid_i(valid[2]),
    .ready_o(ready[2]), .serial_o(serial[2]), .busy_o(busy[2]), .done_o(done[2]));

  function automatic int dwOf(int idx);
    return (idx == 2) ? 4 : 8;
  endfunction

  function automatic int cpbOf(int idx);
    return (idx == 2) ? 1 : 4;
  endfunction

  function automatic int penOf(int idx);
    return (idx == 1) ? 1 : 0;
  endfunction

  // Frame as a list of line levels: start, data LSB first, optional parity, stop.
  function automatic logic expBit(int idx, logic [7:0] word, int k);
    int dw;
    int ones;
    dw = dwOf(idx);
    ones = 0;
    for (int i = 0; i < dw; i++) ones += int'(word[i]);
    if (k == 0) return 1'b0;
    if (k <= dw) return word[k-1];
    if (penOf(idx) == 1 && k == dw + 1) return logic'(ones % 2);
    return 1'b1;
  endfunction

  task automatic checkVal(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a word and waits (bounded) for acceptance; returns one cycle after the accept edge.
  task automatic applyStimulus(int idx, logic [7:0] word, bit keepValid);
    int n;
    valid[idx] = 1'b1;
    data[idx]  = word;
    n = 0;
    while (ready[idx] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checkVal($sformatf("ready_wait%0d", idx), 32'(ready[idx]), 32'd1);
    step();
    if (!keepValid) valid[idx] = 1'b0;
  endtask

  // Walks a whole frame from its first start-bit cycle, ending in the first IDLE cycle.
  task automatic checkOutput(int idx, logic [7:0] word, bit intrude);
    int total;
    total = (dwOf(idx) + 2 + penOf(idx)) * cpbOf(idx);
    for (int c = 0; c < total; c++) begin
      checkVal($sformatf("serial%0d_c%0d", idx, c), 32'(serial[idx]),
               32'(expBit(idx, word, c / cpbOf(idx))));
      checkVal($sformatf("busy%0d_c%0d", idx, c), 32'(busy[idx]), 32'd1);
      checkVal($sformatf("ready%0d_c%0d", idx, c), 32'(ready[idx]), 32'd0);
      checkVal($sformatf("done%0d_c%0d", idx, c), 32'(done[idx]), 32'd0);
      if (intrude && c >= 8) begin
        valid[idx] = 1'b1;
        data[idx]  = (c == total - 1) ? 8'h3C : 8'($urandom);
      end
      step();
    end
    checkVal($sformatf("done%0d_end", idx), 32'(done[idx]), 32'd1);
    checkVal($sformatf("ready%0d_end", idx), 32'(ready[idx]), 32'd1);
    checkVal($sformatf("busy%0d_end", idx), 32'(busy[idx]), 32'd0);
    checkVal($sformatf("serial%0d_end", idx), 32'(serial[idx]), 32'd1);
  endtask

  initial begin
    logic [7:0] word;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("rst_serial%0d", i), 32'(serial[i]), 32'd1);
      checkVal($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      checkVal($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
      checkVal($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
    end
    rst_n = 1'b1;
    step();

    $display("[TB] single frame 0xA5");
    applyStimulus(0, 8'hA5, 1'b0);
    checkOutput(0, 8'hA5, 1'b0);
    step();
    checkVal("done_once_A5", 32'(done[0]), 32'd0);

    $display("[TB] parity frames 0x07 and 0x03");
    applyStimulus(1, 8'h07, 1'b0);
    checkOutput(1, 8'h07, 1'b0);
    applyStimulus(1, 8'h03, 1'b0);
    checkOutput(1, 8'h03, 1'b0);

    $display("[TB] back-to-back 0x00 then 0xFF");
    applyStimulus(0, 8'h00, 1'b1);
    data[0] = 8'hFF;
    checkOutput(0, 8'h00, 1'b0);
    applyStimulus(0, 8'hFF, 1'b0);
    checkOutput(0, 8'hFF, 1'b0);
    step();
    checkVal("done_once_FF", 32'(done[0]), 32'd0);

    $display("[TB] busy rejection 0x55 then 0x3C");
    applyStimulus(0, 8'h55, 1'b0);
    checkOutput(0, 8'h55, 1'b1);
    applyStimulus(0, 8'h3C, 1'b0);
    checkOutput(0, 8'h3C, 1'b0);
    step();

    $display("[TB] reset during data bit 3");
    word = 8'hC6;
    applyStimulus(0, word, 1'b0);
    repeat (16) step();
    checkVal("pre_reset_bit3", 32'(serial[0]), 32'(word[3]));
    rst_n = 1'b0;
    #1;
    checkVal("abort_serial", 32'(serial[0]), 32'd1);
    checkVal("abort_busy", 32'(busy[0]), 32'd0);
    checkVal("abort_done", 32'(done[0]), 32'd0);
    step();
    checkVal("abort_done_held", 32'(done[0]), 32'd0);
    rst_n = 1'b1;
    step();
    checkVal("post_reset_done", 32'(done[0]), 32'd0);
    checkVal("post_reset_serial", 32'(serial[0]), 32'd1);
    applyStimulus(0, 8'h81, 1'b0);
    checkOutput(0, 8'h81, 1'b0);

    $display("[TB] one clock per bit 0xA");
    applyStimulus(2, 8'h0A, 1'b0);
    checkOutput(2, 8'h0A, 1'b0);

    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      for (int idx = 0; idx < 3; idx++) begin
        word = 8'($urandom);
        repeat ($urandom_range(0, 3)) step();
        applyStimulus(idx, word, 1'b0);
        checkOutput(idx, word, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
